// File: rtl/basys_mem_ctrl.sv
// Push-button sequencer for a single-port synchronous RAM on the Basys board.
// Optional per-button debounce filter: define BASYS_MEM_CTRL_DEBOUNCE_EN.
module basys_mem_ctrl #(
    parameter int ADDR_W          = 4,
    parameter int DATA_W          = 16,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] SW,
    input  logic [4:0]        BTN,
    output logic [DATA_W-1:0] LED,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_WAIT,
        S_RD_CAP,
        S_CLEAR
    } state_t;

    state_t            r_state;
    logic [4:0]        r_sync1;
    logic [4:0]        r_sync2;
    logic [4:0]        r_prev;
    logic [4:0]        r_armed;
    logic [1:0]        r_warm;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_sweep;
    logic [ADDR_W-1:0] r_memAddr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_led;
    logic              r_busy;

    logic [4:0]        w_level;
    logic [4:0]        w_pulse;
    logic              w_warmDone;
    logic [ADDR_W-1:0] w_addrInc;
    logic [ADDR_W-1:0] w_addrDec;
    logic [ADDR_W-1:0] w_sweepInc;

    assign w_warmDone = (r_warm == 2'd2);

    // A button only arms once the synchronizer has shown it released after reset,
    // so a button held through reset release cannot fire a command.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_armed <= '0;
            r_warm  <= '0;
        end else begin
            r_sync1 <= BTN;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
            if (!w_warmDone) begin
                r_warm <= r_warm + 2'd1;
            end else begin
                r_armed <= r_armed | ~r_sync2;
            end
        end
    end

`ifdef BASYS_MEM_CTRL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] r_dbCnt [5];
    logic [4:0]       r_dbLevel;

    // Each debounced level follows the synchronizer only after a full run of stable cycles.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dbLevel <= '0;
            for (int i = 0; i < 5; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_dbLevel[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_dbLevel[i] <= r_sync2[i];
                    r_dbCnt[i]   <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_level = r_dbLevel;
`else
    assign w_level = r_sync2;
`endif

    assign w_pulse    = w_level & ~r_prev & r_armed;
    assign w_addrInc  = r_addr + ADDR_W'(1);
    assign w_addrDec  = r_addr - ADDR_W'(1);
    assign w_sweepInc = r_sweep + ADDR_W'(1);

    // Commands are accepted only in IDLE; the if-chain order gives the command priority.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_sweep   <= '0;
            r_memAddr <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_led     <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_we <= 1'b0;
                    if (w_pulse[4]) begin
                        r_state   <= S_CLEAR;
                        r_sweep   <= '0;
                        r_memAddr <= '0;
                        r_we      <= 1'b1;
                        r_wdata   <= '0;
                        r_busy    <= 1'b1;
                    end else if (w_pulse[0]) begin
                        r_state   <= S_WRITE;
                        r_memAddr <= r_addr;
                        r_we      <= 1'b1;
                        r_wdata   <= SW;
                        r_busy    <= 1'b1;
                    end else if (w_pulse[1]) begin
                        r_state   <= S_RD_WAIT;
                        r_memAddr <= r_addr;
                        r_busy    <= 1'b1;
                    end else if (w_pulse[2]) begin
                        r_addr    <= w_addrInc;
                        r_memAddr <= w_addrInc;
                    end else if (w_pulse[3]) begin
                        r_addr    <= w_addrDec;
                        r_memAddr <= w_addrDec;
                    end else begin
                        r_memAddr <= r_addr;
                    end
                end
                S_WRITE: begin
                    r_state   <= S_IDLE;
                    r_we      <= 1'b0;
                    r_busy    <= 1'b0;
                    r_memAddr <= r_addr;
                end
                S_RD_WAIT: begin
                    r_state   <= S_RD_CAP;
                    r_memAddr <= r_addr;
                end
                S_RD_CAP: begin
                    r_state <= S_IDLE;
                    r_led   <= mem_rdata;
                    r_busy  <= 1'b0;
                end
                S_CLEAR: begin
                    if (r_sweep == '1) begin
                        r_state   <= S_IDLE;
                        r_we      <= 1'b0;
                        r_busy    <= 1'b0;
                        r_led     <= '0;
                        r_memAddr <= r_addr;
                    end else begin
                        r_sweep   <= w_sweepInc;
                        r_memAddr <= w_sweepInc;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign LED       = r_led;
    assign mem_addr  = r_memAddr;
    assign mem_we    = r_we;
    assign mem_wdata = r_wdata;
    assign busy      = r_busy;

endmodule
